// File: rtl/motor_seq_pkg.sv
// motor_seq_pkg: shared definitions for the paint-dispense motor sequencer.
//   - seq_state_e : sequencer state encoding
//   - CH_*        : active channel codes (0=none, 1=R, 2=Y, 3=B)
//   - MOT_*       : one-hot motor enables ([2]=R, [1]=Y, [0]=B)
//   - helpers decoding a state into its motor / channel / class
package motor_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN_R  = 3'd1,
        S_GAP_RY = 3'd2,
        S_RUN_Y  = 3'd3,
        S_GAP_YB = 3'd4,
        S_RUN_B  = 3'd5,
        S_DONE   = 3'd6
    } seq_state_e;

    localparam logic [1:0] CH_NONE = 2'd0;
    localparam logic [1:0] CH_R    = 2'd1;
    localparam logic [1:0] CH_Y    = 2'd2;
    localparam logic [1:0] CH_B    = 2'd3;

    localparam logic [2:0] MOT_OFF = 3'b000;
    localparam logic [2:0] MOT_R   = 3'b100;
    localparam logic [2:0] MOT_Y   = 3'b010;
    localparam logic [2:0] MOT_B   = 3'b001;

    function automatic logic [2:0] state_motor(input seq_state_e s);
        logic [2:0] m;
        case (s)
            S_RUN_R: m = MOT_R;
            S_RUN_Y: m = MOT_Y;
            S_RUN_B: m = MOT_B;
            default: m = MOT_OFF;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] state_channel(input seq_state_e s);
        logic [1:0] c;
        case (s)
            S_RUN_R: c = CH_R;
            S_RUN_Y: c = CH_Y;
            S_RUN_B: c = CH_B;
            default: c = CH_NONE;
        endcase
        return c;
    endfunction

    function automatic logic is_run(input seq_state_e s);
        return (s == S_RUN_R) || (s == S_RUN_Y) || (s == S_RUN_B);
    endfunction

    function automatic logic is_gap(input seq_state_e s);
        return (s == S_GAP_RY) || (s == S_GAP_YB);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into a one-cycle time-unit pulse.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : restart the count from zero (wins over en)
//   en         : count enable; the count freezes while low
//   tick       : high for one cycle every TICK_DIV enabled cycles
// The count wraps at TICK_DIV-1. tick does not depend on clr, so the
// owner may derive clr from logic that consumes tick.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_dispense_sequencer.sv
// motor_dispense_sequencer: runs the R, Y, B dispense motors one after
// another for latched durations, with an all-off gap between executed
// channels. Zero-duration channels are skipped without a gap.
//   clk, reset      : clock, asynchronous active-high reset
//   start           : strobe, latches t_r/t_y/t_b and starts a sequence
//   abort           : level, returns to idle at the next edge (no done)
//   pause           : only with MOTOR_SEQ_PAUSE_EN; freezes run/gap timing
//                     and switches the motor off while high
//   t_r, t_y, t_b   : channel durations in time units
//   motores         : one-hot motor enables [2]=R [1]=Y [0]=B
//   busy            : high in every state except idle
//   done            : one-cycle pulse on normal completion
//   active_ch       : 0=none, 1=R, 2=Y, 3=B
// Optional feature macro: MOTOR_SEQ_PAUSE_EN.
module motor_dispense_sequencer
    import motor_seq_pkg::*;
#(
    parameter int unsigned TIME_W     = 8,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef MOTOR_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    input  logic [TIME_W-1:0] t_r,
    input  logic [TIME_W-1:0] t_y,
    input  logic [TIME_W-1:0] t_b,
    output logic [2:0]        motores,
    output logic              busy,
    output logic              done,
    output logic [1:0]        active_ch
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_GAP = (GAP_CYCLES != 0);

    seq_state_e        state_q, state_d;
    logic [TIME_W-1:0] tr_q, tr_d, ty_q, ty_d, tb_q, tb_d;
    logic [TIME_W-1:0] unit_q, unit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [2:0]        motores_q, motores_d;
    logic [1:0]        ch_q, ch_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              in_run, in_gap, hold;
    logic              tick, state_chg;
    logic              run_end, gap_end;
    logic [TIME_W-1:0] cur_t;

    assign in_run = is_run(state_q);
    assign in_gap = is_gap(state_q);

`ifdef MOTOR_SEQ_PAUSE_EN
    assign hold = pause && (in_run || in_gap);
`else
    assign hold = 1'b0;
`endif

    // Every state entry restarts the prescaler and counters.
    assign state_chg = (state_d != state_q);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state_chg),
        .en    (in_run && !hold),
        .tick  (tick)
    );

    always_comb begin
        case (state_q)
            S_RUN_R: cur_t = tr_q;
            S_RUN_Y: cur_t = ty_q;
            S_RUN_B: cur_t = tb_q;
            default: cur_t = '0;
        endcase
    end

    assign run_end = tick && (unit_q == cur_t - TIME_W'(1));
    assign gap_end = in_gap && !hold && (gap_q == GAP_LAST);

    // Next state and time latches
    always_comb begin
        state_d = state_q;
        tr_d    = tr_q;
        ty_d    = ty_q;
        tb_d    = tb_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    tr_d = t_r;
                    ty_d = t_y;
                    tb_d = t_b;
                    if (t_r != '0)      state_d = S_RUN_R;
                    else if (t_y != '0) state_d = S_RUN_Y;
                    else if (t_b != '0) state_d = S_RUN_B;
                    else                state_d = S_DONE;
                end
            end
            S_RUN_R: begin
                if (run_end) begin
                    if (ty_q != '0)      state_d = HAS_GAP ? S_GAP_RY : S_RUN_Y;
                    else if (tb_q != '0) state_d = HAS_GAP ? S_GAP_YB : S_RUN_B;
                    else                 state_d = S_DONE;
                end
            end
            S_GAP_RY: begin
                if (gap_end) state_d = S_RUN_Y;
            end
            S_RUN_Y: begin
                if (run_end) begin
                    if (tb_q != '0) state_d = HAS_GAP ? S_GAP_YB : S_RUN_B;
                    else            state_d = S_DONE;
                end
            end
            S_GAP_YB: begin
                if (gap_end) state_d = S_RUN_B;
            end
            S_RUN_B: begin
                if (run_end) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Unit and gap counters
    always_comb begin
        unit_d = unit_q;
        gap_d  = gap_q;
        if (state_chg) begin
            unit_d = '0;
            gap_d  = '0;
        end else begin
            if (tick)             unit_d = unit_q + TIME_W'(1);
            if (in_gap && !hold)  gap_d  = gap_q + 1'b1;
        end
    end

    // Registered outputs decoded from the upcoming state. A held state
    // switches its motor off one cycle after pause is sampled; as counting
    // also stops on that sampled cycle, total motor-on time is preserved.
    always_comb begin
        motores_d = state_motor(state_d);
        if (hold && !state_chg) begin
            motores_d = MOT_OFF;
        end
        ch_d   = state_channel(state_d);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tr_q      <= '0;
            ty_q      <= '0;
            tb_q      <= '0;
            unit_q    <= '0;
            gap_q     <= '0;
            motores_q <= MOT_OFF;
            ch_q      <= CH_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tr_q      <= tr_d;
            ty_q      <= ty_d;
            tb_q      <= tb_d;
            unit_q    <= unit_d;
            gap_q     <= gap_d;
            motores_q <= motores_d;
            ch_q      <= ch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign motores   = motores_q;
    assign active_ch = ch_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_motor_dispense_sequencer.sv
// Directed bench for motor_dispense_sequencer (TICK_DIV=4, GAP_CYCLES=2).
module tb_motor_dispense_sequencer;

    localparam int LOG_MAX = 64;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
`ifdef MOTOR_SEQ_PAUSE_EN
    logic       pause;
`endif
    logic [7:0] t_r, t_y, t_b;
    logic [2:0] motores;
    logic       busy;
    logic       done;
    logic [1:0] active_ch;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] mot_log [LOG_MAX];
    logic [1:0] ch_log  [LOG_MAX];
    logic [2:0] seg_v   [16];
    int         seg_l   [16];
    int         seg_n;
    logic [2:0] exp_v   [8];
    int         exp_l   [8];
    int         exp_n;
    int         d_idx;
    int         cnt;

    motor_dispense_sequencer #(
        .TIME_W     (8),
        .TICK_DIV   (4),
        .GAP_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
`ifdef MOTOR_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .t_r       (t_r),
        .t_y       (t_y),
        .t_b       (t_b),
        .motores   (motores),
        .busy      (busy),
        .done      (done),
        .active_ch (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] r, input logic [7:0] y, input logic [7:0] b);
        t_r   = r;
        t_y   = y;
        t_b   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_r   = 8'hAA;
        t_y   = 8'h55;
        t_b   = 8'h33;
    endtask

    // Logs one sample per cycle, starting the cycle after the start edge,
    // until done is seen. Optionally injects a start or a pause window.
    task automatic run_log(input int inj_at, input int p_at, input int p_len,
                           input string tag, output int didx);
        didx = -1;
        for (int i = 0; i < LOG_MAX; i++) begin
            mot_log[i] = motores;
            ch_log[i]  = active_ch;
            if (done === 1'b1) begin
                didx = i;
                break;
            end
            start = (i == inj_at);
            if (i == inj_at) t_r = 8'd9;
`ifdef MOTOR_SEQ_PAUSE_EN
            pause = (i >= p_at) && (i < p_at + p_len);
`endif
            @(negedge clk);
        end
        start = 1'b0;
`ifdef MOTOR_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        check({tag, "_done_seen"}, 32'(didx >= 0), 32'd1);
    endtask

    task automatic set_exp(input int i, input logic [2:0] v, input int l);
        exp_v[i] = v;
        exp_l[i] = l;
        if (i + 1 > exp_n) exp_n = i + 1;
    endtask

    task automatic check_segs(input string tag, input int n);
        seg_n = 0;
        for (int i = 0; i < 16; i++) begin
            seg_v[i] = 3'bxxx;
            seg_l[i] = 0;
        end
        for (int i = 0; i < n; i++) begin
            if (seg_n > 0 && seg_v[seg_n-1] === mot_log[i]) begin
                seg_l[seg_n-1]++;
            end else if (seg_n < 16) begin
                seg_v[seg_n] = mot_log[i];
                seg_l[seg_n] = 1;
                seg_n++;
            end
        end
        check({tag, "_nseg"}, 32'(seg_n), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            check($sformatf("%s_seg%0d_mot", tag, i), 32'(seg_v[i]), 32'(exp_v[i]));
            check($sformatf("%s_seg%0d_len", tag, i), 32'(seg_l[i]), 32'(exp_l[i]));
        end
        exp_n = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
`ifdef MOTOR_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        t_r   = '0;
        t_y   = '0;
        t_b   = '0;
        exp_n = 0;

        // Reset state
        #2;
        check("rst_motores", 32'(motores), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ch", 32'(active_ch), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic 3/2/1 sequence: 12 R, 2 gap, 8 Y, 2 gap, 4 B, then done
        pulse_start(8'd3, 8'd2, 8'd1);
        run_log(-1, -1, 0, "basic", d_idx);
        check("basic_done_idx", 32'(d_idx), 32'd28);
        check("basic_done_busy", 32'(busy), 32'd1);
        check("basic_ch_r", 32'(ch_log[0]), 32'd1);
        check("basic_ch_gap", 32'(ch_log[12]), 32'd0);
        check("basic_ch_y", 32'(ch_log[14]), 32'd2);
        check("basic_ch_b", 32'(ch_log[24]), 32'd3);
        set_exp(0, 3'b100, 12);
        set_exp(1, 3'b000, 2);
        set_exp(2, 3'b010, 8);
        set_exp(3, 3'b000, 2);
        set_exp(4, 3'b001, 4);
        check_segs("basic", d_idx);
        @(negedge clk);
        check("basic_post_busy", 32'(busy), 32'd0);
        check("basic_post_done", 32'(done), 32'd0);

        // Skip: only yellow runs, no gaps
        pulse_start(8'd0, 8'd2, 8'd0);
        run_log(-1, -1, 0, "skip", d_idx);
        check("skip_done_idx", 32'(d_idx), 32'd8);
        cnt = 0;
        for (int i = 0; i < 8; i++) if (ch_log[i] != 2'd2) cnt++;
        check("skip_ch_not_y", 32'(cnt), 32'd0);
        set_exp(0, 3'b010, 8);
        check_segs("skip", d_idx);
        @(negedge clk);

        // All zero: done the cycle after the start edge
        pulse_start(8'd0, 8'd0, 8'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_motores", 32'(motores), 32'd0);
        @(negedge clk);
        check("zero_post_done", 32'(done), 32'd0);
        check("zero_post_busy", 32'(busy), 32'd0);

        // Abort on the 5th cycle of RUN_Y (index 18)
        pulse_start(8'd3, 8'd2, 8'd1);
        repeat (18) @(negedge clk);
        check("abort_pre_mot", 32'(motores), 32'b010);
        abort = 1'b1;
        @(negedge clk);
        check("abort_motores", 32'(motores), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ch", 32'(active_ch), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        abort = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) cnt++;
        end
        check("abort_quiet", 32'(cnt), 32'd0);
        pulse_start(8'd0, 8'd1, 8'd0);
        run_log(-1, -1, 0, "restart", d_idx);
        check("restart_done_idx", 32'(d_idx), 32'd4);
        set_exp(0, 3'b010, 4);
        check_segs("restart", d_idx);
        @(negedge clk);

        // Start while busy with t_r=9 is ignored
        pulse_start(8'd3, 8'd0, 8'd0);
        run_log(3, -1, 0, "busystart", d_idx);
        check("busystart_done_idx", 32'(d_idx), 32'd12);
        set_exp(0, 3'b100, 12);
        check_segs("busystart", d_idx);
        @(negedge clk);
        check("busystart_post_busy", 32'(busy), 32'd0);

`ifdef MOTOR_SEQ_PAUSE_EN
        // 10-cycle pause in RUN_R: R window 22 cycles, 12 motor-on
        pulse_start(8'd3, 8'd2, 8'd1);
        run_log(-1, 3, 10, "pause", d_idx);
        check("pause_done_idx", 32'(d_idx), 32'd38);
        cnt = 0;
        for (int i = 0; i < d_idx; i++) if (ch_log[i] == 2'd1) cnt++;
        check("pause_r_window", 32'(cnt), 32'd22);
        set_exp(0, 3'b100, 4);
        set_exp(1, 3'b000, 10);
        set_exp(2, 3'b100, 8);
        set_exp(3, 3'b000, 2);
        set_exp(4, 3'b010, 8);
        set_exp(5, 3'b000, 2);
        set_exp(6, 3'b001, 4);
        check_segs("pause", d_idx);
        @(negedge clk);
`endif

        // Reset mid RUN_B, asynchronous to clk
        pulse_start(8'd3, 8'd2, 8'd1);
        repeat (25) @(negedge clk);
        check("mrst_pre_mot", 32'(motores), 32'b001);
        check("mrst_pre_ch", 32'(active_ch), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mrst_motores", 32'(motores), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_ch", 32'(active_ch), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst_after_busy", 32'(busy), 32'd0);
        check("mrst_after_mot", 32'(motores), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
